// File: rtl/decode_issue_stage.sv
// Decode/issue stage: register file with write-back bypass, load-use and branch hazard
// detection, branch/JAL resolution, and the ID/EX pipeline register.
// Optional perf counters are enabled with `define DECODE_PERF_CNT_EN.
module decode_issue_stage #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int RA_W  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic            ex_stall,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_reg_write,
    output logic            fetch_hold,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            ex_valid,
    output logic [31:0]     ex_instr,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [RA_W-1:0] ex_rs1,
    output logic [RA_W-1:0] ex_rs2,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_mem_read,
    output logic            ex_reg_write
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_redirect_cnt
`endif
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;

    assign opcode = id_instr[6:0];
    assign funct3 = id_instr[14:12];
    assign rs1    = id_instr[15 +: RA_W];
    assign rs2    = id_instr[20 +: RA_W];
    assign rd     = id_instr[7 +: RA_W];

    logic is_load, is_branch, is_jal, use_rs1, use_rs2, writes_rd;

    always_comb begin
        is_load   = (opcode == OP_LOAD);
        is_branch = (opcode == OP_BRANCH);
        is_jal    = (opcode == OP_JAL);
        use_rs1   = (opcode == OP_REG) || (opcode == OP_IMM) || is_load ||
                    (opcode == OP_STORE) || is_branch || (opcode == OP_JALR);
        use_rs2   = (opcode == OP_REG) || (opcode == OP_STORE) || is_branch;
        writes_rd = (opcode == OP_REG) || (opcode == OP_IMM) || is_load ||
                    (opcode == OP_JALR) || (opcode == OP_LUI) ||
                    (opcode == OP_AUIPC) || is_jal;
    end

    // Register file; entry 0 is never written so it stays zero after reset.
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (wb_we && (wb_rd != '0)) begin
            regs_d[wb_rd] = wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    always_comb begin
        rs1_val = regs_q[rs1];
        if (rs1 == '0) begin
            rs1_val = '0;
        end else if (wb_we && (wb_rd == rs1)) begin
            rs1_val = wb_data;
        end
        rs2_val = regs_q[rs2];
        if (rs2 == '0) begin
            rs2_val = '0;
        end else if (wb_we && (wb_rd == rs2)) begin
            rs2_val = wb_data;
        end
    end

    logic            ex_valid_q, ex_valid_d;
    logic [31:0]     ex_instr_q, ex_instr_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d;
    logic [XLEN-1:0] ex_rs1_data_q, ex_rs1_data_d;
    logic [XLEN-1:0] ex_rs2_data_q, ex_rs2_data_d;
    logic [RA_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [RA_W-1:0] ex_rs2_q, ex_rs2_d;
    logic [RA_W-1:0] ex_rd_q, ex_rd_d;
    logic            ex_mem_read_q, ex_mem_read_d;
    logic            ex_reg_write_q, ex_reg_write_d;

    // Branches compare in decode, so any in-flight producer (EX or MEM) must drain to WB first.
    logic load_use, br_dep, hazard;
    logic rs1_ex_hit, rs2_ex_hit, rs1_mem_hit, rs2_mem_hit;

    always_comb begin
        rs1_ex_hit  = use_rs1 && (rs1 != '0) && ex_valid_q && ex_reg_write_q && (rs1 == ex_rd_q);
        rs2_ex_hit  = use_rs2 && (rs2 != '0) && ex_valid_q && ex_reg_write_q && (rs2 == ex_rd_q);
        rs1_mem_hit = use_rs1 && (rs1 != '0) && mem_reg_write && (rs1 == mem_rd);
        rs2_mem_hit = use_rs2 && (rs2 != '0) && mem_reg_write && (rs2 == mem_rd);
        load_use    = id_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) &&
                      ((use_rs1 && (rs1 == ex_rd_q)) || (use_rs2 && (rs2 == ex_rd_q)));
        br_dep      = id_valid && is_branch &&
                      (rs1_ex_hit || rs2_ex_hit || rs1_mem_hit || rs2_mem_hit);
        hazard      = load_use || br_dep;
    end

    assign fetch_hold = hazard || ex_stall;

    logic [XLEN-1:0] b_imm;
    logic [XLEN-1:0] j_imm;
    logic            br_cond;
    logic            taken;
    logic [XLEN-1:0] target;

    always_comb begin
        b_imm = {{(XLEN-12){id_instr[31]}}, id_instr[7], id_instr[30:25], id_instr[11:8], 1'b0};
        j_imm = {{(XLEN-20){id_instr[31]}}, id_instr[19:12], id_instr[20], id_instr[30:21], 1'b0};
        case (funct3)
            3'b000:  br_cond = (rs1_val == rs2_val);
            3'b001:  br_cond = (rs1_val != rs2_val);
            3'b100:  br_cond = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_cond = (rs1_val <  rs2_val);
            3'b111:  br_cond = (rs1_val >= rs2_val);
            default: br_cond = 1'b0;
        endcase
        taken  = id_valid && !hazard && !ex_stall && ((is_branch && br_cond) || is_jal);
        target = is_jal ? (id_pc + j_imm) : (id_pc + b_imm);
        redirect_valid = taken;
        redirect_pc    = taken ? target : '0;
    end

    // Hold on back-pressure beats bubble; a held hazard is re-evaluated next cycle.
    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_instr_d     = ex_instr_q;
        ex_pc_d        = ex_pc_q;
        ex_rs1_data_d  = ex_rs1_data_q;
        ex_rs2_data_d  = ex_rs2_data_q;
        ex_rs1_d       = ex_rs1_q;
        ex_rs2_d       = ex_rs2_q;
        ex_rd_d        = ex_rd_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_reg_write_d = ex_reg_write_q;
        if (!ex_stall) begin
            if (hazard) begin
                ex_valid_d     = 1'b0;
                ex_instr_d     = '0;
                ex_pc_d        = '0;
                ex_rs1_data_d  = '0;
                ex_rs2_data_d  = '0;
                ex_rs1_d       = '0;
                ex_rs2_d       = '0;
                ex_rd_d        = '0;
                ex_mem_read_d  = 1'b0;
                ex_reg_write_d = 1'b0;
            end else begin
                ex_valid_d     = id_valid;
                ex_instr_d     = id_instr;
                ex_pc_d        = id_pc;
                ex_rs1_data_d  = rs1_val;
                ex_rs2_data_d  = rs2_val;
                ex_rs1_d       = rs1;
                ex_rs2_d       = rs2;
                ex_rd_d        = rd;
                ex_mem_read_d  = id_valid && is_load;
                ex_reg_write_d = id_valid && writes_rd && (rd != '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_instr_q     <= '0;
            ex_pc_q        <= '0;
            ex_rs1_data_q  <= '0;
            ex_rs2_data_q  <= '0;
            ex_rs1_q       <= '0;
            ex_rs2_q       <= '0;
            ex_rd_q        <= '0;
            ex_mem_read_q  <= 1'b0;
            ex_reg_write_q <= 1'b0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_instr_q     <= ex_instr_d;
            ex_pc_q        <= ex_pc_d;
            ex_rs1_data_q  <= ex_rs1_data_d;
            ex_rs2_data_q  <= ex_rs2_data_d;
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            ex_rd_q        <= ex_rd_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_reg_write_q <= ex_reg_write_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_instr     = ex_instr_q;
    assign ex_pc        = ex_pc_q;
    assign ex_rs1_data  = ex_rs1_data_q;
    assign ex_rs2_data  = ex_rs2_data_q;
    assign ex_rs1       = ex_rs1_q;
    assign ex_rs2       = ex_rs2_q;
    assign ex_rd        = ex_rd_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_reg_write = ex_reg_write_q;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    always_comb begin
        stall_cnt_d    = stall_cnt_q + {31'd0, (hazard && !ex_stall)};
        redirect_cnt_d = redirect_cnt_q + {31'd0, redirect_valid};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign perf_stall_cnt    = stall_cnt_q;
    assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule
